// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared operation and FSM-state encodings for the iterative
//               multiply/divide unit, plus small decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

   // Operation select as presented on the op port
   typedef enum logic [1:0] {
      OP_MULTU = 2'b00,
      OP_MULT  = 2'b01,
      OP_DIVU  = 2'b10,
      OP_DIV   = 2'b11
   } op_e;

   // Control FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   // Signed variants work on magnitudes and fix the sign at the end
   function automatic logic op_is_signed(input op_e o);
      return (o == OP_MULT) || (o == OP_DIV);
   endfunction

   function automatic logic op_is_div(input op_e o);
      return (o == OP_DIVU) || (o == OP_DIV);
   endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative HI/LO multiply/divide unit. One shift-add (multiply)
//               or restoring shift-subtract (divide) step per RUN cycle on
//               operand magnitudes, sign fix-up on the final step. HI/LO can
//               be written directly while the unit is not running.
//               Optional divide datapath: define MULDIV_DIV_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   input  logic             we_hi,
   input  logic             we_lo,
   input  logic [WIDTH-1:0] wd,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int               c_cnt_w    = $clog2(WIDTH);
   localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(WIDTH - 1);

   state_e               r_state;
   state_e               w_state_nxt;
   logic [c_cnt_w-1:0]   r_cnt;
   logic [WIDTH-1:0]     r_acc;      // upper product half / partial remainder
   logic [WIDTH-1:0]     r_q;        // multiplier shifting out / quotient shifting in
   logic [WIDTH-1:0]     r_b;        // multiplicand / divisor magnitude
   logic                 r_neg_q;    // negate product (mult) or quotient (div)
   logic [WIDTH-1:0]     r_hi;
   logic [WIDTH-1:0]     r_lo;

   op_e                  w_op;
   logic                 w_op_ok;
   logic                 w_sgn;
   logic                 w_start_ok;
   logic                 w_finish;
   logic [WIDTH-1:0]     w_a_mag;
   logic [WIDTH-1:0]     w_b_mag;
   logic [WIDTH:0]       w_sum;
   logic [WIDTH-1:0]     w_acc_nxt;
   logic [WIDTH-1:0]     w_q_nxt;
   logic [2*WIDTH-1:0]   w_prod;
   logic [2*WIDTH-1:0]   w_prod_fix;
   logic [WIDTH-1:0]     w_res_hi;
   logic [WIDTH-1:0]     w_res_lo;

`ifdef MULDIV_DIV_EN
   logic                 r_is_div;
   logic                 r_neg_r;    // remainder takes the dividend sign
   logic                 r_div0;
   logic [WIDTH-1:0]     r_a;        // original dividend, returned on divide by zero
   logic [WIDTH:0]       w_shift;
   logic [WIDTH:0]       w_trial;
`endif

   assign w_op  = op_e'(op);
   assign w_sgn = op_is_signed(w_op);

`ifdef MULDIV_DIV_EN
   assign w_op_ok = 1'b1;
`else
   // Divide requests are dropped entirely when the divider is not built
   assign w_op_ok = !op_is_div(w_op);
`endif

   // flush beats start; start is only honoured outside RUN
   assign w_start_ok = start && !flush && (r_state != ST_RUN) && w_op_ok;
   assign w_finish   = (r_state == ST_RUN) && (r_cnt == '0) && !flush;

   assign w_a_mag = (w_sgn && a[WIDTH-1]) ? -a : a;
   assign w_b_mag = (w_sgn && b[WIDTH-1]) ? -b : b;

   assign hi = r_hi;
   assign lo = r_lo;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and status outputs
   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_start_ok) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            busy = 1'b1;
            if (flush)              w_state_nxt = ST_IDLE;
            else if (r_cnt == '0)   w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            done        = 1'b1;
            w_state_nxt = w_start_ok ? ST_RUN : ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // One shift-add or restoring shift-subtract step on the shared registers
   always_comb begin
      w_sum     = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : '0);
      w_acc_nxt = w_sum[WIDTH:1];
      w_q_nxt   = {w_sum[0], r_q[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
      w_shift   = {r_acc, r_q[WIDTH-1]};
      w_trial   = w_shift - {1'b0, r_b};
      if (r_is_div) begin
         if (!w_trial[WIDTH]) begin
            w_acc_nxt = w_trial[WIDTH-1:0];
            w_q_nxt   = {r_q[WIDTH-2:0], 1'b1};
         end else begin
            w_acc_nxt = w_shift[WIDTH-1:0];
            w_q_nxt   = {r_q[WIDTH-2:0], 1'b0};
         end
      end
`endif
   end

   // Sign fix-up and result placement for the final step
   always_comb begin
      w_prod     = {w_acc_nxt, w_q_nxt};
      w_prod_fix = r_neg_q ? -w_prod : w_prod;
      w_res_hi   = w_prod_fix[2*WIDTH-1:WIDTH];
      w_res_lo   = w_prod_fix[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
      if (r_is_div) begin
         if (r_div0) begin
            w_res_lo = '1;
            w_res_hi = r_a;
         end else begin
            w_res_lo = r_neg_q ? -w_q_nxt : w_q_nxt;
            w_res_hi = r_neg_r ? -w_acc_nxt : w_acc_nxt;
         end
      end
`endif
   end

   // Operand capture on start, then iterate and count down while running
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt   <= '0;
         r_acc   <= '0;
         r_q     <= '0;
         r_b     <= '0;
         r_neg_q <= 1'b0;
      end else if (w_start_ok) begin
         r_cnt   <= c_cnt_init;
         r_acc   <= '0;
         r_q     <= w_a_mag;
         r_b     <= w_b_mag;
         r_neg_q <= w_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
      end else if (r_state == ST_RUN) begin
         r_acc <= w_acc_nxt;
         r_q   <= w_q_nxt;
         if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      end
   end

`ifdef MULDIV_DIV_EN
   // Divide-only operand attributes captured with the operands
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_is_div <= 1'b0;
         r_neg_r  <= 1'b0;
         r_div0   <= 1'b0;
         r_a      <= '0;
      end else if (w_start_ok) begin
         r_is_div <= op_is_div(w_op);
         r_neg_r  <= w_sgn && a[WIDTH-1];
         r_div0   <= (b == '0);
         r_a      <= a;
      end
   end
`endif

   // HI/LO: result on DONE entry, direct writes outside RUN take priority
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hi <= '0;
         r_lo <= '0;
      end else begin
         if (w_finish) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
         end
         if (r_state != ST_RUN) begin
            if (we_hi) r_hi <= wd;
            if (we_lo) r_lo <= wd;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit (WIDTH=32): directed
//               corner cases with literal expectations, then randomized
//               traffic compared every cycle against a behavioural model.
//               Honours MULDIV_DIV_EN to match the DUT build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

   localparam int W = 32;
`ifdef MULDIV_DIV_EN
   localparam bit DIV_OK = 1'b1;
`else
   localparam bit DIV_OK = 1'b0;
`endif

   logic         clk   = 1'b0;
   logic         rst   = 1'b1;
   logic         start = 1'b0;
   logic [1:0]   op    = 2'b00;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic         flush = 1'b0;
   logic         we_hi = 1'b0;
   logic         we_lo = 1'b0;
   logic [W-1:0] wd    = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   // Behavioural model state
   bit           m_run  = 1'b0;
   int           m_left = 0;
   bit           m_done = 1'b0;
   logic [W-1:0] m_hi   = '0;
   logic [W-1:0] m_lo   = '0;
   logic [63:0]  m_res  = '0;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .flush (flush),
      .we_hi (we_hi),
      .we_lo (we_lo),
      .wd    (wd),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Architectural result {HI, LO} for an operation
   function automatic logic [63:0] ref_result(input logic [1:0] o,
                                              input logic [W-1:0] x,
                                              input logic [W-1:0] y);
      longint      sx, sy, sq, sr;
      logic [63:0] p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      p  = '0;
      case (o)
         2'b00: p = {32'd0, x} * {32'd0, y};
         2'b01: p = sx * sy;
         default: begin
            if (y == '0) begin
               p = {x, 32'hFFFF_FFFF};
            end else if (o == 2'b10) begin
               p = {x % y, x / y};
            end else begin
               sq = sx / sy;
               sr = sx % sy;
               p  = {sr[31:0], sq[31:0]};
            end
         end
      endcase
      return p;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: an accepted op occupies exactly W busy cycles, then one done cycle
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_run  <= 1'b0;
         m_left <= 0;
         m_done <= 1'b0;
         m_hi   <= '0;
         m_lo   <= '0;
      end else begin
         m_done <= 1'b0;
         if (m_run) begin
            if (flush) begin
               m_run <= 1'b0;
            end else if (m_left == 1) begin
               m_run  <= 1'b0;
               m_done <= 1'b1;
               m_hi   <= m_res[63:32];
               m_lo   <= m_res[31:0];
            end else begin
               m_left <= m_left - 1;
            end
         end else begin
            if (we_hi) m_hi <= wd;
            if (we_lo) m_lo <= wd;
            if (start && !flush && (DIV_OK || !op[1])) begin
               m_run  <= 1'b1;
               m_left <= W;
               m_res  <= ref_result(op, a, b);
            end
         end
      end
   end

   // Every-cycle comparison of DUT outputs against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", {63'd0, busy}, {63'd0, m_run});
         chk("done", {63'd0, done}, {63'd0, m_done});
         chk("hi", {32'd0, hi}, {32'd0, m_hi});
         chk("lo", {32'd0, lo}, {32'd0, m_lo});
      end
   end

   // Present a one-cycle start; returns at the negedge of cycle 1
   task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Called at cycle 1; returns at the negedge where done is seen
   task automatic wait_done(output int lat);
      lat = 1;
      while (done !== 1'b1 && lat <= W + 8) begin
         @(negedge clk);
         lat++;
      end
      if (done !== 1'b1) begin
         n_tests++;
         n_fail++;
         $display("FAIL wait_done: no done pulse within %0d cycles", W + 8);
      end
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return 32'd1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'($urandom_range(0, 15));
         default: return 32'($urandom);
      endcase
   endfunction

   initial begin
      int lat;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("reset_hi", {32'd0, hi}, 64'd0);
      chk("reset_lo", {32'd0, lo}, 64'd0);
      chk("reset_busy", {63'd0, busy}, 64'd0);
      chk("reset_done", {63'd0, done}, 64'd0);
      chk_en = 1'b1;

      // Model pins
      chk("model_multu", ref_result(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
      chk("model_mult", ref_result(2'b01, 32'hFFFF_FFFD, 32'd7), 64'hFFFF_FFFF_FFFF_FFEB);
      chk("model_div", ref_result(2'b11, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
      chk("model_div_ovf", ref_result(2'b11, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);
      chk("model_div0", ref_result(2'b10, 32'd5, 32'd0), 64'h0000_0005_FFFF_FFFF);

      // MULTU all-ones squared, full latency
      issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk("multu_busy_c1", {63'd0, busy}, 64'd1);
      wait_done(lat);
      chk("multu_latency", 64'(lat), 64'd33);
      chk("multu_hi", {32'd0, hi}, 64'hFFFF_FFFE);
      chk("multu_lo", {32'd0, lo}, 64'h0000_0001);

      // MULT -3*7, then back-to-back start in the DONE cycle
      @(negedge clk);
      issue(2'b01, 32'hFFFF_FFFD, 32'd7);
      wait_done(lat);
      chk("mult_hi", {32'd0, hi}, 64'hFFFF_FFFF);
      chk("mult_lo", {32'd0, lo}, 64'hFFFF_FFEB);
      issue(2'b00, 32'd6, 32'd7);
      chk("b2b_busy", {63'd0, busy}, 64'd1);
      wait_done(lat);
      chk("b2b_latency", 64'(lat), 64'd33);
      chk("b2b_lo", {32'd0, lo}, 64'd42);
      @(negedge clk);

`ifdef MULDIV_DIV_EN
      issue(2'b11, 32'hFFFF_FFF9, 32'd2);
      wait_done(lat);
      chk("div_lo", {32'd0, lo}, 64'hFFFF_FFFD);
      chk("div_hi", {32'd0, hi}, 64'hFFFF_FFFF);
      @(negedge clk);
      issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(lat);
      chk("divovf_lo", {32'd0, lo}, 64'h8000_0000);
      chk("divovf_hi", {32'd0, hi}, 64'd0);
      @(negedge clk);
      issue(2'b10, 32'd5, 32'd0);
      wait_done(lat);
      chk("div0_latency", 64'(lat), 64'd33);
      chk("div0_lo", {32'd0, lo}, 64'hFFFF_FFFF);
      chk("div0_hi", {32'd0, hi}, 64'd5);
      @(negedge clk);
`else
      issue(2'b10, 32'd5, 32'd0);
      chk("nodiv_busy", {63'd0, busy}, 64'd0);
      chk("nodiv_hi", {32'd0, hi}, 64'd0);
      chk("nodiv_lo", {32'd0, lo}, 64'd42);
      repeat (3) @(negedge clk);
      chk("nodiv_done", {63'd0, done}, 64'd0);
`endif

      // MTHI, then flush in RUN cycle 10 with an ignored we_hi in cycle 3
      we_hi = 1'b1;
      wd    = 32'h0000_1234;
      @(negedge clk);
      we_hi = 1'b0;
      chk("mthi", {32'd0, hi}, 64'h1234);
      issue(2'b00, 32'd2, 32'd3);
      repeat (2) @(negedge clk);
      we_hi = 1'b1;
      wd    = 32'h0000_DEAD;
      @(negedge clk);
      we_hi = 1'b0;
      repeat (6) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_busy", {63'd0, busy}, 64'd0);
      chk("flush_done", {63'd0, done}, 64'd0);
      chk("flush_hi", {32'd0, hi}, 64'h1234);

      // Asynchronous reset in RUN cycle 5
      @(negedge clk);
      issue(2'b00, 32'd9, 32'd9);
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", {63'd0, busy}, 64'd0);
      chk("arst_done", {63'd0, done}, 64'd0);
      chk("arst_hi", {32'd0, hi}, 64'd0);
      chk("arst_lo", {32'd0, lo}, 64'd0);
      #1 rst = 1'b0;
      @(negedge clk);
      issue(2'b00, 32'd6, 32'd7);
      wait_done(lat);
      chk("arst_mul_latency", 64'(lat), 64'd33);
      chk("arst_mul_lo", {32'd0, lo}, 64'd42);
      chk("arst_mul_hi", {32'd0, hi}, 64'd0);

      // Randomized traffic, checked every cycle by the compare process
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         start = ($urandom_range(0, 3) == 0);
         op    = 2'($urandom_range(0, 3));
         a     = pick();
         b     = pick();
         flush = m_run && ($urandom_range(0, 29) == 0);
         we_hi = ($urandom_range(0, 7) == 0);
         we_lo = ($urandom_range(0, 7) == 0);
         wd    = 32'($urandom);
      end
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      we_hi = 1'b0;
      we_lo = 1'b0;
      repeat (W + 4) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
